// File: rtl/hazard_detection_unit_if.sv
// Bus between the ID-stage pipeline control and the hazard detection unit.
// The pipeline side uses the master modport, the hazard unit uses slave.
interface hazard_detection_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       IF_ID_RS1_i;
  logic [4:0]       IF_ID_RS2_i;
  logic [4:0]       ID_EX_RD_i;
  logic             ID_EX_MemRead_i;
  logic             Branch_taken_i;
  logic             MemBusy_i;
  logic             Hazard_o;
  logic             PCWrite_o;
  logic             IF_IDWrite_o;
  logic             Freeze_o;
  logic             Flush_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             err_o;

  modport slave (
    input  IF_ID_RS1_i, IF_ID_RS2_i, ID_EX_RD_i, ID_EX_MemRead_i,
           Branch_taken_i, MemBusy_i,
    output Hazard_o, PCWrite_o, IF_IDWrite_o, Freeze_o, Flush_o,
           stall_cnt_o, flush_cnt_o, err_o
  );

  modport master (
    output IF_ID_RS1_i, IF_ID_RS2_i, ID_EX_RD_i, ID_EX_MemRead_i,
           Branch_taken_i, MemBusy_i,
    input  Hazard_o, PCWrite_o, IF_IDWrite_o, Freeze_o, Flush_o,
           stall_cnt_o, flush_cnt_o, err_o
  );
endinterface

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: one-bubble load-use stall, full-pipeline freeze
// while data memory is busy, IF/ID flush on taken branch, saturating event
// counters and a sticky memory-timeout error flag.
module hazard_detection_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  hazard_detection_unit_if.slave bus
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  typedef enum logic {RUN, MEM_WAIT} state_t;

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic              err_reg, err_next;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;

  logic load_use;
  logic hazard, pc_write, ifid_write, freeze, flush;
  logic stall_inc, flush_inc;

  // Load in EX whose destination (never x0) feeds a source of the ID instruction
  assign load_use = bus.ID_EX_MemRead_i && (bus.ID_EX_RD_i != 5'd0) &&
                    ((bus.ID_EX_RD_i == bus.IF_ID_RS1_i) ||
                     (bus.ID_EX_RD_i == bus.IF_ID_RS2_i));

  // Next-state and strobe logic; the freeze follows MemBusy_i directly so
  // the cycle busy drops already evaluates hazards/branches (N busy cycles
  // cost exactly N frozen cycles)
  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    err_next   = err_reg;
    hazard     = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    freeze     = 1'b0;
    flush      = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (bus.MemBusy_i) begin
      freeze     = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      if (state_reg == RUN) begin
        state_next = MEM_WAIT;
        wait_next  = WAIT_W'(1);
      end else if (wait_reg == WAIT_MAX) begin
        // Busy has outlasted the allowed window: latch the error
        err_next = 1'b1;
      end else begin
        wait_next = wait_reg + WAIT_W'(1);
      end
    end else begin
      if (state_reg == MEM_WAIT) begin
        state_next = RUN;
        wait_next  = '0;
      end
      if (load_use) begin
        // Bubble wins over a coincident branch; the branch re-resolves later
        hazard     = 1'b1;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        stall_inc  = 1'b1;
      end else if (bus.Branch_taken_i) begin
        flush     = 1'b1;
        flush_inc = 1'b1;
      end
    end
  end

  // State, wait counter and sticky error registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= RUN;
      wait_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      err_reg   <= err_next;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && (stall_cnt_reg != CNT_MAX))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_inc && (flush_cnt_reg != CNT_MAX))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  assign bus.Hazard_o     = hazard;
  assign bus.PCWrite_o    = pc_write;
  assign bus.IF_IDWrite_o = ifid_write;
  assign bus.Freeze_o     = freeze;
  assign bus.Flush_o      = flush;
  assign bus.stall_cnt_o  = stall_cnt_reg;
  assign bus.flush_cnt_o  = flush_cnt_reg;
  assign bus.err_o        = err_reg;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed testbench for hazard_detection_unit (TIMEOUT=4, CNT_W=4).
module tb_hazard_detection_unit;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  hazard_detection_unit_if #(.CNT_W(CNT_W)) hif ();

  hazard_detection_unit #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (hif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic br, input logic busy);
    hif.ID_EX_MemRead_i = mr;
    hif.ID_EX_RD_i      = rd;
    hif.IF_ID_RS1_i     = rs1;
    hif.IF_ID_RS2_i     = rs2;
    hif.Branch_taken_i  = br;
    hif.MemBusy_i       = busy;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    step();
    step();
    // Reset state
    check("rst_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    check("rst_stall",   32'(hif.stall_cnt_o), 32'd0);
    check("rst_flush",   32'(hif.flush_cnt_o), 32'd0);
    check("rst_err",     32'(hif.err_o), 32'd0);
    rst = 1'b0;

    // Load-use on rs1
    drive(1'b1, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0);
    check("lu_hazard",  32'(hif.Hazard_o), 32'd1);
    check("lu_pcwrite", 32'(hif.PCWrite_o), 32'd0);
    check("lu_ifid",    32'(hif.IF_IDWrite_o), 32'd0);
    check("lu_freeze",  32'(hif.Freeze_o), 32'd0);
    step();
    check("lu_stall_cnt", 32'(hif.stall_cnt_o), 32'd1);
    drive(1'b0, 5'd5, 5'd5, 5'd1, 1'b0, 1'b0);
    check("lu_bubble_hazard", 32'(hif.Hazard_o), 32'd0);
    check("lu_bubble_pc",     32'(hif.PCWrite_o), 32'd1);

    // rd = x0 never hazards
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("x0_hazard",  32'(hif.Hazard_o), 32'd0);
    check("x0_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    step();
    check("x0_stall_cnt", 32'(hif.stall_cnt_o), 32'd1);
    check("x0_flush_cnt", 32'(hif.flush_cnt_o), 32'd0);

    // Taken branch, then branch coincident with load-use on rs2
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    check("br_flush",   32'(hif.Flush_o), 32'd1);
    check("br_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    step();
    check("br_flush_cnt", 32'(hif.flush_cnt_o), 32'd1);
    drive(1'b1, 5'd7, 5'd3, 5'd7, 1'b1, 1'b0);
    check("brlu_hazard", 32'(hif.Hazard_o), 32'd1);
    check("brlu_flush",  32'(hif.Flush_o), 32'd0);
    step();
    check("brlu_flush_cnt", 32'(hif.flush_cnt_o), 32'd1);
    check("brlu_stall_cnt", 32'(hif.stall_cnt_o), 32'd2);

    // Busy for 3 cycles with load-use pending
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("busy_freeze", 32'(hif.Freeze_o), 32'd1);
      check("busy_hazard", 32'(hif.Hazard_o), 32'd0);
      check("busy_pcwrite", 32'(hif.PCWrite_o), 32'd0);
      step();
      check("busy_stall_held", 32'(hif.stall_cnt_o), 32'd2);
    end
    drive(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
    check("resume_freeze", 32'(hif.Freeze_o), 32'd0);
    check("resume_hazard", 32'(hif.Hazard_o), 32'd1);
    step();
    check("resume_stall_cnt", 32'(hif.stall_cnt_o), 32'd3);
    check("resume_err", 32'(hif.err_o), 32'd0);

    // Busy for 6 cycles: err sets after the 5th edge and sticks
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step();
      check("to_err", 32'(hif.err_o), (i >= 5) ? 32'd1 : 32'd0);
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    check("to_release_freeze", 32'(hif.Freeze_o), 32'd0);
    step();
    check("to_err_sticky", 32'(hif.err_o), 32'd1);

    // Mid-cycle asynchronous reset
    #2;
    rst = 1'b1;
    #1;
    check("arst_err",   32'(hif.err_o), 32'd0);
    check("arst_stall", 32'(hif.stall_cnt_o), 32'd0);
    check("arst_flush", 32'(hif.flush_cnt_o), 32'd0);
    check("arst_pcwrite", 32'(hif.PCWrite_o), 32'd1);
    step();
    rst = 1'b0;

    // 20 consecutive load-use cycles saturate at 15
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 10) check("sat_mid", 32'(hif.stall_cnt_o), 32'd10);
      if (i == 15) check("sat_reach", 32'(hif.stall_cnt_o), 32'd15);
    end
    check("sat_final", 32'(hif.stall_cnt_o), 32'd15);
    check("sat_flush", 32'(hif.flush_cnt_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
